// File: rtl/qspis_pkg.sv
// Shared types and constants for the QSPI slave Wishbone arbiter.
package qspis_pkg;

  localparam int TMO_DEF = 255;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One-hot grant vector for a single-bit owner index.
  function automatic logic [1:0] owner_onehot(input logic owner);
    if (owner) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/qspis_wb_tmo.sv
// Saturating transaction timeout counter: cleared while idle, counts
// each busy cycle, flags the last permitted cycle.
module qspis_wb_tmo
  import qspis_pkg::*;
#(
  parameter int TMO_CYCLES = TMO_DEF
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TMO_CYCLES);
  localparam logic [CW-1:0] LAST_C = CW'(TMO_CYCLES - 1);
  localparam logic [CW-1:0] MAX_C  = {CW{1'b1}};

  logic [CW-1:0] cnt_r;

  // Busy-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == LAST_C);

endmodule

// File: rtl/qspis_wb_arb.sv
// Two-master round-robin Wishbone arbiter with per-transaction timeout.
// Master 0 is the QSPI bridge, master 1 a debug/host master.
module qspis_wb_arb
  import qspis_pkg::*;
#(
  parameter int TMO_CYCLES = TMO_DEF
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  output logic [SEL_W-1:0] s_sel_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  output logic [1:0]       gnt_o,
  output logic             tmo_o
);

  arb_state_e state_r;
  logic       owner_r;
  logic       rr_ptr_r;
  logic [1:0] gnt_r;

  logic             m0_req_s, m1_req_s, busy_s;
  logic             own_cyc_s, own_stb_s, own_we_s;
  logic [ADR_W-1:0] own_adr_s;
  logic [DAT_W-1:0] own_dat_s;
  logic [SEL_W-1:0] own_sel_s;
  logic             grant_owner_s, done_s, expire_s, tmo_fire_s, leave_s;

  assign m0_req_s = m0_cyc_i & m0_stb_i;
  assign m1_req_s = m1_cyc_i & m1_stb_i;
  assign busy_s   = (state_r == BUSY);

  // Tie-break goes to rr_ptr only when both masters ask at once.
  assign grant_owner_s = (m0_req_s & m1_req_s) ? rr_ptr_r : m1_req_s;

  // A slave response always wins over a timeout landing in the same cycle;
  // an owner that has already dropped cyc is treated as an abort instead.
  assign done_s     = busy_s & (s_ack_i | s_err_i);
  assign tmo_fire_s = busy_s & expire_s & own_cyc_s & ~(s_ack_i | s_err_i);
  assign leave_s    = busy_s & (done_s | ~own_cyc_s | tmo_fire_s);
  assign tmo_o      = tmo_fire_s;
  assign gnt_o      = gnt_r;

  qspis_wb_tmo #(.TMO_CYCLES(TMO_CYCLES)) u_tmo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (~busy_s),
    .en      (busy_s),
    .expire  (expire_s)
  );

  // Select the current owner's request bundle.
  always_comb begin
    if (owner_r) begin
      own_cyc_s = m1_cyc_i;
      own_stb_s = m1_stb_i;
      own_we_s  = m1_we_i;
      own_adr_s = m1_adr_i;
      own_dat_s = m1_dat_i;
      own_sel_s = m1_sel_i;
    end else begin
      own_cyc_s = m0_cyc_i;
      own_stb_s = m0_stb_i;
      own_we_s  = m0_we_i;
      own_adr_s = m0_adr_i;
      own_dat_s = m0_dat_i;
      own_sel_s = m0_sel_i;
    end
  end

  // Drive the slave port while busy and route the response to the owner only.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = {ADR_W{1'b0}};
    s_dat_o  = {DAT_W{1'b0}};
    s_sel_o  = {SEL_W{1'b0}};
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = {DAT_W{1'b0}};
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = {DAT_W{1'b0}};
    if (busy_s) begin
      s_cyc_o = own_cyc_s & own_stb_s & ~tmo_fire_s;
      s_stb_o = own_cyc_s & own_stb_s & ~tmo_fire_s;
      s_we_o  = own_we_s;
      s_adr_o = own_adr_s;
      s_dat_o = own_dat_s;
      s_sel_o = own_sel_s;
      if (owner_r) begin
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | tmo_fire_s;
        m1_dat_o = s_ack_i ? s_dat_i : {DAT_W{1'b0}};
      end else begin
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | tmo_fire_s;
        m0_dat_o = s_ack_i ? s_dat_i : {DAT_W{1'b0}};
      end
    end else begin
      s_cyc_o = 1'b0;
    end
  end

  // Arbitration FSM: grant in IDLE, hold until response, abort or timeout.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      rr_ptr_r <= 1'b0;
      gnt_r    <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_req_s | m1_req_s) begin
            owner_r <= grant_owner_s;
            gnt_r   <= owner_onehot(grant_owner_s);
            state_r <= BUSY;
          end else begin
            gnt_r   <= 2'b00;
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (leave_s) begin
            rr_ptr_r <= ~owner_r;
            gnt_r    <= 2'b00;
            state_r  <= IDLE;
          end else begin
            state_r  <= BUSY;
          end
        end
        default: begin
          gnt_r   <= 2'b00;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
